demux1x4_tdm: RTL
=================

# demux1x4_tdm

Receive-side counterpart of the 4:1 mux datapath. Takes a time-division-multiplexed stream, one sample per slot over four slots, and locks to a frame-sync marker. It demultiplexes each frame into four registered channel outputs and pulses `out_valid` once per complete frame. It sits at the far end of a link driven by a 4:1 mux whose select rotates 00→01→10→11.

## Interface
- `WIDTH`, default 1, bit width of each slot sample and of each channel output.

- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; one clock, reset is asynchronous and active-low.
- `in_valid`  input  1  qualifies `in_data` and `frame_sync` on this edge.
- `in_data`  input  WIDTH  slot sample.
- `frame_sync`  input  1  marks the current sample as slot 0; ignored when `in_valid`=0.
- `out0`  output  WIDTH  channel 0, the slot-0 sample of the last complete frame.
- `out1`  output  WIDTH  channel 1, the slot-1 sample.
- `out2`  output  WIDTH  channel 2, the slot-2 sample.
- `out3`  output  WIDTH  channel 3, the slot-3 sample.
- `sel1`  output  1  MSB of the slot index expected for the next valid sample.
- `sel0`  output  1  LSB of that slot index.
- `out_valid`  output  1  one-cycle pulse; `out0..out3` hold a new complete frame.
- `sync_err`  output  1  one-cycle pulse on a framing violation.

## Operation
- FSM states: HUNT and LOCKED. Slot counter is 2 bits, drives `{sel1,sel0}`. Shadow registers `sh0..sh2` are WIDTH bits each.
- Reset (async, `rst_n`=0):
  - state=HUNT, counter=00, `sh0..sh2`=0.
  - `out0..out3`=0, `out_valid`=0, `sync_err`=0.
- HUNT:
  - Samples with `frame_sync`=0 are discarded, with no error.
  - On `in_valid`&`frame_sync`: sh0←`in_data`, counter←01, state→LOCKED.
- LOCKED, `in_valid`=1, `frame_sync`=0, counter≠00:
  - Counter 01 or 10: sh[counter]←`in_data`, counter increments.
  - Counter 11: out0←sh0, out1←sh1, out2←sh2, out3←`in_data`. Then `out_valid` pulses, counter wraps to 00, and the FSM stays LOCKED.
- LOCKED, counter=00, `in_valid`&`frame_sync`: sh0←`in_data`, counter←01. This is the normal frame start.
- LOCKED, counter=00, `in_valid`, `frame_sync`=0 (missing sync):
  - `sync_err` pulses, the sample is discarded.
  - State→HUNT, counter stays 00.
- LOCKED, counter≠00, `in_valid`&`frame_sync` (early sync):
  - `sync_err` pulses and the partial frame is dropped; outputs are unchanged.
  - The sample is taken as the new slot 0: sh0←`in_data`, counter←01, state stays LOCKED.
- `in_valid`=0: no state, counter, shadow or output change. Gaps of any length are allowed mid-frame.
- `out0..out3` change only on frame completion; all four update on the same edge. Between completions they hold.
- `out_valid` and `sync_err` are never high in the same cycle.

## Timing
- All outputs are registered; there is no combinational input→output path.
- Latency: the slot-3 sample is captured on edge N. `out0..out3` and `out_valid`=1 are visible after edge N, and `out_valid` returns to 0 after edge N+1 unless another frame completes there. The minimum frame period is 4 cycles, so back-to-back frames give `out_valid` every 4th cycle.
- `sync_err` is high for exactly the cycle after the offending edge.
- `{sel1,sel0}` reflects the counter after each edge. It reads 00 in HUNT and after reset.
- `rst_n` asserted mid-frame clears outputs, FSM and counter immediately, with no clock needed. Release is synchronous to `clk`; the first sample accepted is on the first rising edge after release. Any partial frame is lost.

## Test plan
- Reset check: hold `rst_n`=0 with `clk` toggling, then release. Required: `out0..out3`=0, `out_valid`=0, `sync_err`=0, `{sel1,sel0}`=00, with no output activity before the first `frame_sync`.
- One-hot frame, WIDTH=1: send 1,0,0,0 on 4 consecutive valid cycles with sync on the first. Required: after the 4th edge out0=1, out1=out2=out3=0 and `out_valid`=1 for 1 cycle. Repeat with 0,1,0,0, then 0,0,1,0, then 0,0,0,1; the lone 1 must land in out1, then out2, then out3 respectively.
- Gaps: a frame 1,1,0,1 with `in_valid`=0 for 3 cycles between slots 1 and 2. Required: `{sel1,sel0}` holds at 10 during the gap, one `out_valid` pulse at the end, outputs 1,1,0,1.
- Early sync: after a completed frame with outputs 1,0,0,0, send a new frame 0,1, then `frame_sync` with data 1, then 1,1,0. Required: `sync_err` pulse after the third sample and no output change. Then `out_valid` fires with outputs 1,1,1,0.
- Missing sync: complete a frame, then send a slot-0 sample with `frame_sync`=0 followed by 3 more samples. Required: `sync_err` pulse, FSM in HUNT, no `out_valid`, outputs unchanged until the next `frame_sync`.
- Async reset mid-frame: assert `rst_n`=0 after slot 2, between clock edges. Required: outputs and counter are 0 immediately. After release, a full synced frame 0,0,0,1 yields out3=1 with a single `out_valid` pulse.

Source files
------------

// File: rtl/demux1x4_tdm.sv
// Four-slot TDM receiver: hunts for a frame-sync marker, then demultiplexes each
// complete frame into four registered channel outputs with a one-cycle out_valid pulse.
module demux1x4_tdm #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   input  logic             frame_sync,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic             sel1,
   output logic             sel0,
   output logic             out_valid,
   output logic             sync_err
);

   typedef enum logic {
      HUNT   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [1:0]       cnt_q, cnt_d;
   logic [WIDTH-1:0] sh0_q, sh0_d;
   logic [WIDTH-1:0] sh1_q, sh1_d;
   logic [WIDTH-1:0] sh2_q, sh2_d;
   logic [WIDTH-1:0] out0_q, out0_d;
   logic [WIDTH-1:0] out1_q, out1_d;
   logic [WIDTH-1:0] out2_q, out2_d;
   logic [WIDTH-1:0] out3_q, out3_d;
   logic             out_valid_q, out_valid_d;
   logic             sync_err_q, sync_err_d;

   always_comb begin
      // NOTE: every signal gets a hold/idle default first, so no path can infer a latch.
      state_d     = state_q;
      cnt_d       = cnt_q;
      sh0_d       = sh0_q;
      sh1_d       = sh1_q;
      sh2_d       = sh2_q;
      out0_d      = out0_q;
      out1_d      = out1_q;
      out2_d      = out2_q;
      out3_d      = out3_q;
      out_valid_d = 1'b0;
      sync_err_d  = 1'b0;

      if (in_valid) begin
         unique case (state_q)
            HUNT: begin
               if (frame_sync) begin
                  sh0_d   = in_data;
                  cnt_d   = 2'b01;
                  state_d = LOCKED;
               end
            end
            LOCKED: begin
               if (frame_sync) begin
                  // A sync anywhere but slot 0 drops the partial frame and restarts it.
                  sync_err_d = (cnt_q != 2'b00);
                  sh0_d      = in_data;
                  cnt_d      = 2'b01;
               end else begin
                  unique case (cnt_q)
                     2'b00: begin
                        sync_err_d = 1'b1;
                        state_d    = HUNT;
                     end
                     2'b01: begin
                        sh1_d = in_data;
                        cnt_d = 2'b10;
                     end
                     2'b10: begin
                        sh2_d = in_data;
                        cnt_d = 2'b11;
                     end
                     2'b11: begin
                        out0_d      = sh0_q;
                        out1_d      = sh1_q;
                        out2_d      = sh2_q;
                        out3_d      = in_data;
                        out_valid_d = 1'b1;
                        cnt_d       = 2'b00;
                     end
                     default: cnt_d = 2'b00;
                  endcase
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= HUNT;
         cnt_q       <= 2'b00;
         sh0_q       <= '0;
         sh1_q       <= '0;
         sh2_q       <= '0;
         out0_q      <= '0;
         out1_q      <= '0;
         out2_q      <= '0;
         out3_q      <= '0;
         out_valid_q <= 1'b0;
         sync_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sh0_q       <= sh0_d;
         sh1_q       <= sh1_d;
         sh2_q       <= sh2_d;
         out0_q      <= out0_d;
         out1_q      <= out1_d;
         out2_q      <= out2_d;
         out3_q      <= out3_d;
         out_valid_q <= out_valid_d;
         sync_err_q  <= sync_err_d;
      end
   end

   assign out0      = out0_q;
   assign out1      = out1_q;
   assign out2      = out2_q;
   assign out3      = out3_q;
   assign sel1      = cnt_q[1];
   assign sel0      = cnt_q[0];
   assign out_valid = out_valid_q;
   assign sync_err  = sync_err_q;

endmodule
